// File: rtl/wb_trace_checker.sv
// Golden-trace checker for the CPU writeback debug port.
// Compares each committed register write, in order, against an external
// expected-trace ROM that has a 1-cycle read latency. Latches the first error,
// and reports pass after TRACE_LEN matching commits.
module wb_trace_checker #(
    parameter int unsigned TRACE_LEN = 64,
    parameter int unsigned TRACE_AW  = 8,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         debug_wb_pc,
    input  logic                debug_wb_rf_wen,
    input  logic [4:0]          debug_wb_rf_addr,
    input  logic [31:0]         debug_wb_rf_wdata,
    output logic [TRACE_AW-1:0] trace_raddr,
    input  logic [68:0]         trace_rdata,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          err_code,
    output logic [TRACE_AW-1:0] err_index,
    output logic [31:0]         err_pc,
    output logic [4:0]          err_addr,
    output logic [31:0]         err_wdata,
    output logic [TRACE_AW:0]   commit_cnt
);

    // The timer only needs to hold 0..TIMEOUT-1.
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrMismatch = 2'd1;
    localparam logic [1:0] ErrOverrun  = 2'd2;
    localparam logic [1:0] ErrTimeout  = 2'd3;

    typedef enum logic [1:0] {StLoad, StRun, StPass, StFail} state_e;

    state_e              state_q, state_d;
    logic [68:0]         exp_q, exp_d;
    logic [TRACE_AW-1:0] ptr_q, ptr_d;
    logic [TRACE_AW:0]   cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0]       timer_q, timer_d;
    logic [1:0]          code_q, code_d;
    logic [TRACE_AW-1:0] index_q, index_d;
    logic [68:0]         errobs_q, errobs_d;

    logic        commit;
    logic [68:0] observed;

    assign commit   = debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0);
    assign observed = {debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata};
    assign cnt_inc  = cnt_q + {{TRACE_AW{1'b0}}, 1'b1};

    // Next-state logic and combinational ROM lookahead address.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        code_d      = code_q;
        index_d     = index_q;
        errobs_d    = errobs_q;
        trace_raddr = ptr_q;

        unique case (state_q)
            StLoad: begin
                trace_raddr = TRACE_AW'(1);
                exp_d       = trace_rdata;
                ptr_d       = '0;
                timer_d     = '0;
                if (commit) begin
                    state_d  = StFail;
                    code_d   = ErrMismatch;
                    index_d  = '0;
                    errobs_d = observed;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Fetch one entry further ahead when the current one is consumed.
                trace_raddr = ptr_q + (commit ? TRACE_AW'(2) : TRACE_AW'(1));
                if (commit) begin
                    timer_d = '0;
                    if (observed == exp_q) begin
                        exp_d = trace_rdata;
                        ptr_d = ptr_q + TRACE_AW'(1);
                        cnt_d = cnt_inc;
                        if (cnt_inc == (TRACE_AW + 1)'(TRACE_LEN)) begin
                            state_d = StPass;
                        end
                    end else begin
                        state_d  = StFail;
                        code_d   = ErrMismatch;
                        index_d  = ptr_q;
                        errobs_d = observed;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d  = StFail;
                    code_d   = ErrTimeout;
                    index_d  = ptr_q;
                    errobs_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StPass: begin
                if (commit) begin
                    state_d  = StFail;
                    code_d   = ErrOverrun;
                    index_d  = TRACE_AW'(TRACE_LEN);
                    errobs_d = observed;
                end
            end
            StFail: begin
                // Terminal; everything stays frozen until reset.
            end
            default: state_d = StLoad;
        endcase

        // Entry 0 must be requested while reset is held so LOAD can capture it.
        if (reset) begin
            trace_raddr = '0;
        end
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StLoad;
            exp_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            code_q   <= ErrNone;
            index_q  <= '0;
            errobs_q <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            code_q   <= code_d;
            index_q  <= index_d;
            errobs_q <= errobs_d;
        end
    end

    assign done       = (state_q == StPass) || (state_q == StFail);
    assign pass       = (state_q == StPass);
    assign fail       = (state_q == StFail);
    assign err_code   = code_q;
    assign err_index  = index_q;
    assign err_pc     = errobs_q[68:37];
    assign err_addr   = errobs_q[36:32];
    assign err_wdata  = errobs_q[31:0];
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker with a 4-entry trace and TIMEOUT=20.
module tb_wb_trace_checker;

    localparam int unsigned LEN = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned TO  = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc;
    logic          wen;
    logic [4:0]    addr;
    logic [31:0]   wdata;
    logic [AW-1:0] trace_raddr;
    logic [68:0]   trace_rdata;
    logic          done, pass, fail;
    logic [1:0]    err_code;
    logic [AW-1:0] err_index;
    logic [31:0]   err_pc;
    logic [4:0]    err_addr;
    logic [31:0]   err_wdata;
    logic [AW:0]   commit_cnt;

    int tests = 0;
    int fails = 0;

    logic [68:0] rom [0:255];

    always #5 clk = ~clk;

    wb_trace_checker #(.TRACE_LEN(LEN), .TRACE_AW(AW), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .debug_wb_pc       (pc),
        .debug_wb_rf_wen   (wen),
        .debug_wb_rf_addr  (addr),
        .debug_wb_rf_wdata (wdata),
        .trace_raddr       (trace_raddr),
        .trace_rdata       (trace_rdata),
        .done              (done),
        .pass              (pass),
        .fail              (fail),
        .err_code          (err_code),
        .err_index         (err_index),
        .err_pc            (err_pc),
        .err_addr          (err_addr),
        .err_wdata         (err_wdata),
        .commit_cnt        (commit_cnt)
    );

    // Synchronous-read trace ROM, 1-cycle latency.
    always @(posedge clk) trace_rdata <= rom[trace_raddr];

    // Entry i: pc=4*i, rd=i+1, data=0x0F+i (entry 2 expects r3=0x11 at pc 0x8).
    function automatic logic [68:0] ent(int i);
        return {32'(4 * i), 5'(i + 1), 32'(15 + i)};
    endfunction

    typedef struct {
        logic        rst;
        logic        wen;
        logic [68:0] obs;
        logic        done;
        logic        pass;
        logic        fail;
        logic [1:0]  code;
        logic [7:0]  idx;
        logic [68:0] err;
        logic [8:0]  cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic w, logic [68:0] o, logic d, logic p, logic f,
                                logic [1:0] c, logic [7:0] ix, logic [68:0] e, logic [8:0] n);
        vec_t v;
        v.rst = r; v.wen = w; v.obs = o; v.done = d; v.pass = p; v.fail = f;
        v.code = c; v.idx = ix; v.err = e; v.cnt = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [68:0] o);
        reset = r;
        wen   = w;
        pc    = o[68:37];
        addr  = o[36:32];
        wdata = o[31:0];
    endtask

    // Drive one cycle of inputs and return at the following negedge.
    task automatic step(input logic r, input logic w, input logic [68:0] o);
        drive(r, w, o);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 69'd0);
    endtask

    initial begin
        logic [68:0] z, r0w, ovr, bad, badpc;
        z     = '0;
        r0w   = {32'h8, 5'd0, 32'hDEAD};
        ovr   = {32'h100, 5'd5, 32'h55};
        bad   = {32'h8, 5'd3, 32'h12};
        badpc = {32'h10, 5'd1, 32'h0F};
        for (int i = 0; i < 256; i++) rom[i] = ent(i);

        // Clean trace with an r0 write in between, then an overrun.
        vq.push_back(mk(1, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 1, ent(0), 0, 0, 0, 0, 0, z, 1));
        vq.push_back(mk(0, 1, ent(1), 0, 0, 0, 0, 0, z, 2));
        vq.push_back(mk(0, 1, r0w,    0, 0, 0, 0, 0, z, 2));
        vq.push_back(mk(0, 1, ent(2), 0, 0, 0, 0, 0, z, 3));
        vq.push_back(mk(0, 0, z,      0, 0, 0, 0, 0, z, 3));
        vq.push_back(mk(0, 1, ent(3), 1, 1, 0, 0, 0, z, 4));
        vq.push_back(mk(0, 0, z,      1, 1, 0, 0, 0, z, 4));
        vq.push_back(mk(0, 1, ovr,    1, 0, 1, 2, 4, ovr, 4));
        vq.push_back(mk(0, 1, ent(0), 1, 0, 1, 2, 4, ovr, 4));
        // Data mismatch on entry 2; later commits change nothing.
        vq.push_back(mk(1, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 1, ent(0), 0, 0, 0, 0, 0, z, 1));
        vq.push_back(mk(0, 1, ent(1), 0, 0, 0, 0, 0, z, 2));
        vq.push_back(mk(0, 1, bad,    1, 0, 1, 1, 2, bad, 2));
        vq.push_back(mk(0, 1, ent(2), 1, 0, 1, 1, 2, bad, 2));
        vq.push_back(mk(0, 1, ent(3), 1, 0, 1, 1, 2, bad, 2));
        // Commit during LOAD.
        vq.push_back(mk(1, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 1, ent(0), 1, 0, 1, 1, 0, ent(0), 0));
        // Wrong PC on the first commit.
        vq.push_back(mk(1, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 1, badpc,  1, 0, 1, 1, 0, badpc, 0));
        // Reset mid-run, then replay the clean trace back to back.
        vq.push_back(mk(1, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 1, ent(0), 0, 0, 0, 0, 0, z, 1));
        vq.push_back(mk(0, 1, ent(1), 0, 0, 0, 0, 0, z, 2));
        vq.push_back(mk(1, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 0, z,      0, 0, 0, 0, 0, z, 0));
        vq.push_back(mk(0, 1, ent(0), 0, 0, 0, 0, 0, z, 1));
        vq.push_back(mk(0, 1, ent(1), 0, 0, 0, 0, 0, z, 2));
        vq.push_back(mk(0, 1, ent(2), 0, 0, 0, 0, 0, z, 3));
        vq.push_back(mk(0, 1, ent(3), 1, 1, 0, 0, 0, z, 4));

        drive(1'b1, 1'b0, z);
        #1;
        check("raddr_in_reset", 69'(trace_raddr), 69'd0);
        @(negedge clk);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].wen, vq[i].obs);
            check($sformatf("v%0d done", i), 69'(done), 69'(vq[i].done));
            check($sformatf("v%0d pass", i), 69'(pass), 69'(vq[i].pass));
            check($sformatf("v%0d fail", i), 69'(fail), 69'(vq[i].fail));
            check($sformatf("v%0d code", i), 69'(err_code), 69'(vq[i].code));
            check($sformatf("v%0d index", i), 69'(err_index), 69'(vq[i].idx));
            check($sformatf("v%0d err", i), {err_pc, err_addr, err_wdata}, vq[i].err);
            check($sformatf("v%0d cnt", i), 69'(commit_cnt), 69'(vq[i].cnt));
        end

        // ROM lookahead address through reset, LOAD and RUN.
        drive(1'b1, 1'b0, z);
        #1 check("raddr_reset", 69'(trace_raddr), 69'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, z);
        #1 check("raddr_load", 69'(trace_raddr), 69'd1);
        @(negedge clk);
        #1 check("raddr_run_idle", 69'(trace_raddr), 69'd1);
        drive(1'b0, 1'b1, ent(0));
        #1 check("raddr_run_commit", 69'(trace_raddr), 69'd2);
        @(negedge clk);
        drive(1'b0, 1'b1, ent(1));
        #1 check("raddr_run_commit2", 69'(trace_raddr), 69'd3);

        // Timeout: one commit, then silence; fail on the 20th idle edge.
        step(1'b1, 1'b0, z);
        step(1'b0, 1'b0, z);
        step(1'b0, 1'b1, ent(0));
        idle(TO - 1);
        check("to_not_yet", 69'(fail), 69'd0);
        idle(1);
        check("to_fail", 69'(fail), 69'd1);
        check("to_done", 69'(done), 69'd1);
        check("to_code", 69'(err_code), 69'd3);
        check("to_index", 69'(err_index), 69'd1);
        check("to_err", {err_pc, err_addr, err_wdata}, 69'd0);
        check("to_cnt", 69'(commit_cnt), 69'd1);

        // A commit on the expiry cycle wins and restarts the count.
        step(1'b1, 1'b0, z);
        step(1'b0, 1'b0, z);
        step(1'b0, 1'b1, ent(0));
        idle(TO - 1);
        step(1'b0, 1'b1, ent(1));
        check("prio_fail", 69'(fail), 69'd0);
        check("prio_cnt", 69'(commit_cnt), 69'd2);
        idle(TO - 1);
        check("prio_not_yet", 69'(fail), 69'd0);
        idle(1);
        check("prio_to_fail", 69'(fail), 69'd1);
        check("prio_to_index", 69'(err_index), 69'd2);
        check("prio_to_code", 69'(err_code), 69'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
